// File: rtl/jtag_shift_sequencer.sv
// Command-driven JTAG master: turns TAP-reset, IR/DR-scan and idle commands into
// cycle-exact TMS/TDI sequences and collects TDO, parking the TAP in Run-Test/Idle.
module jtag_shift_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  trst_n_pad_in,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  tms_out,
    output logic                  tdi_out,
    input  logic                  tdo_in,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    typedef enum logic [3:0] {
        INIT0, INIT1, IDLE, RST, SEL_DR, SEL_IR,
        CAPTURE, SHIFT, EXIT1, UPDATE, RUN, DONE
    } state_t;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(DATA_WIDTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] RST_LAST = LEN_WIDTH'(5);

    state_t                  r_state;
    state_t                  w_next;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [LEN_WIDTH-1:0]    r_len;
    logic                    r_is_ir;
    logic [DATA_WIDTH-1:0]   r_sr;
    logic [DATA_WIDTH-1:0]   r_cap;
    logic [DATA_WIDTH-1:0]   r_mask;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_err;

    logic w_ready;
    logic w_accept;
    logic w_bad_len;
    logic w_reject;
    logic w_last;
    logic w_tms;
    logic w_cnt_clr;
    logic w_cnt_inc;

    assign w_ready   = (r_state == IDLE) || (r_state == DONE);
    assign w_accept  = cmd_valid && w_ready;
    assign w_bad_len = (cmd_len == LEN_ZERO) || (cmd_len > LEN_MAX);
    assign w_reject  = ((cmd_op == OP_IR) || (cmd_op == OP_DR)) && w_bad_len;
    assign w_last    = (r_cnt == (r_len - LEN_ONE));

    always_ff @(posedge clk or negedge trst_n_pad_in) begin
        if (!trst_n_pad_in) begin
            r_state <= INIT0;
        end else begin
            r_state <= w_next;
        end
    end

    // CAPTURE spans two cycles: the TAP sits in Select-xR, then Capture-xR.
    always_comb begin
        w_next    = r_state;
        w_tms     = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            INIT0: begin
                w_tms  = 1'b1;
                w_next = INIT1;
            end
            INIT1:   w_next = IDLE;
            IDLE, DONE: begin
                if (r_state == DONE) w_next = IDLE;
                if (w_accept) begin
                    w_cnt_clr = 1'b1;
                    case (cmd_op)
                        OP_RESET: w_next = RST;
                        OP_IR, OP_DR: w_next = w_bad_len ? DONE : SEL_DR;
                        default: w_next = (cmd_len == LEN_ZERO) ? DONE : RUN;
                    endcase
                end
            end
            RST: begin
                w_tms = (r_cnt != RST_LAST);
                if (r_cnt == RST_LAST) w_next = DONE;
                else                   w_cnt_inc = 1'b1;
            end
            SEL_DR: begin
                w_tms  = 1'b1;
                w_next = r_is_ir ? SEL_IR : CAPTURE;
            end
            SEL_IR: begin
                w_tms  = 1'b1;
                w_next = CAPTURE;
            end
            CAPTURE: begin
                if (r_cnt == LEN_ONE) begin
                    w_cnt_clr = 1'b1;
                    w_next    = SHIFT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            SHIFT: begin
                w_tms = w_last;
                if (w_last) w_next = EXIT1;
                else        w_cnt_inc = 1'b1;
            end
            EXIT1: begin
                w_tms  = 1'b1;
                w_next = UPDATE;
            end
            UPDATE:  w_next = DONE;
            RUN: begin
                if (w_last) w_next = DONE;
                else        w_cnt_inc = 1'b1;
            end
            default: w_next = INIT0;
        endcase
    end

    always_ff @(posedge clk or negedge trst_n_pad_in) begin
        if (!trst_n_pad_in) begin
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + LEN_ONE;
            // Rejects and zero-length idles complete straight from the accept edge.
            if (w_accept && (w_next == DONE)) begin
                r_rsp_data <= '0;
                r_rsp_err  <= w_reject;
            end else if (!w_ready && (w_next == DONE)) begin
                r_rsp_data <= r_cap;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_len   <= cmd_len;
            r_is_ir <= (cmd_op == OP_IR);
            r_sr    <= cmd_data;
            r_cap   <= '0;
            r_mask  <= DATA_WIDTH'(1);
        end else if (r_state == SHIFT) begin
            r_sr   <= r_sr >> 1;
            r_cap  <= r_cap | (r_mask & {DATA_WIDTH{tdo_in}});
            r_mask <= r_mask << 1;
        end
    end

    assign tms_out   = w_tms;
    assign tdi_out   = (r_state == SHIFT) && r_sr[0];
    assign cmd_ready = w_ready;
    assign rsp_valid = (r_state == DONE);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// Directed bench for jtag_shift_sequencer driving a behavioural TAP controller
// (4-bit IR, BYPASS at 1111, IR capture pattern 1101) with a response scoreboard.
module tb_jtag_shift_sequencer;

    localparam int DW = 32;
    localparam int LW = 6;

    logic          clk;
    logic          trst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic          tms_out;
    logic          tdi_out;
    logic          tdo;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    jtag_shift_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .trst_n_pad_in (trst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_len       (cmd_len),
        .cmd_data      (cmd_data),
        .tms_out       (tms_out),
        .tdi_out       (tdi_out),
        .tdo_in        (tdo),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural TAP controller
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR
    } tap_t;

    tap_t       tap_state;
    tap_t       tap_next;
    logic [3:0] tap_ir;
    logic [3:0] tap_ir_sr;
    logic       tap_byp;
    int         tlr_cnt;

    always_comb begin
        tap_next = tap_state;
        case (tap_state)
            TLR:   tap_next = tms_out ? TLR   : RTI;
            RTI:   tap_next = tms_out ? SELDR : RTI;
            SELDR: tap_next = tms_out ? SELIR : CAPDR;
            CAPDR: tap_next = tms_out ? EX1DR : SHDR;
            SHDR:  tap_next = tms_out ? EX1DR : SHDR;
            EX1DR: tap_next = tms_out ? UPDR  : PAUDR;
            PAUDR: tap_next = tms_out ? EX2DR : PAUDR;
            EX2DR: tap_next = tms_out ? UPDR  : SHDR;
            UPDR:  tap_next = tms_out ? SELDR : RTI;
            SELIR: tap_next = tms_out ? TLR   : CAPIR;
            CAPIR: tap_next = tms_out ? EX1IR : SHIR;
            SHIR:  tap_next = tms_out ? EX1IR : SHIR;
            EX1IR: tap_next = tms_out ? UPIR  : PAUIR;
            PAUIR: tap_next = tms_out ? EX2IR : PAUIR;
            EX2IR: tap_next = tms_out ? UPIR  : SHIR;
            default: tap_next = tms_out ? SELDR : RTI;
        endcase
    end

    always @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            tap_state <= TLR;
            tap_ir    <= 4'b1111;
            tap_ir_sr <= 4'b0000;
            tap_byp   <= 1'b0;
        end else begin
            case (tap_state)
                TLR:   begin tap_ir <= 4'b1111; tlr_cnt <= tlr_cnt + 1; end
                CAPIR: tap_ir_sr <= 4'b1101;
                SHIR:  tap_ir_sr <= {tdi_out, tap_ir_sr[3:1]};
                UPIR:  tap_ir <= tap_ir_sr;
                CAPDR: tap_byp <= 1'b0;
                SHDR:  tap_byp <= tdi_out;
                default: ;
            endcase
            tap_state <= tap_next;
        end
    end

    initial tlr_cnt = 0;
    initial tdo = 1'b0;
    always @(negedge clk) begin
        if (tap_state == SHDR)      tdo <= tap_byp;
        else if (tap_state == SHIR) tdo <= tap_ir_sr[0];
        else                        tdo <= 1'b0;
    end

    // Scoreboard
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tms_exp(input logic [1:0] op, input int len);
        logic [63:0] v;
        int p;
        v = '0;
        p = 0;
        if (op == 2'b00) begin
            v[4:0] = 5'b11111;
        end else if ((op == 2'b01 || op == 2'b10) && len >= 1 && len <= DW) begin
            if (op == 2'b01) begin v[0] = 1'b1; v[1] = 1'b1; p = 2; end
            else             begin v[0] = 1'b1; p = 1; end
            p = p + 2 + (len - 1);
            v[p]     = 1'b1;
            v[p + 1] = 1'b1;
        end
        return v;
    endfunction

    // Call just after the accept edge; returns at the falling edge of the rsp_valid cycle.
    task automatic watch(input string tag, input logic [1:0] op, input int len);
        logic [63:0] obs;
        int   got;
        exp_t e;
        obs = '0;
        got = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            obs[cyc-1] = tms_out;
            if (rsp_valid) begin
                got = cyc;
                break;
            end
        end
        e = sb.pop_front();
        check({tag, "_cycle"}, 64'(got), 64'(e.cyc));
        check({tag, "_data"}, 64'(rsp_data), 64'(e.data));
        check({tag, "_err"}, 64'(rsp_err), 64'(e.err));
        check({tag, "_tms"}, obs, tms_exp(op, len));
    endtask

    task automatic send(input string tag, input logic [1:0] op, input int len,
                        input logic [DW-1:0] data, input logic [DW-1:0] exp_data,
                        input logic exp_err, input int exp_cyc);
        exp_t e;
        cmd_op    = op;
        cmd_len   = LW'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        e.data = exp_data; e.err = exp_err; e.cyc = exp_cyc;
        sb.push_back(e);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        watch(tag, op, len);
    endtask

    task automatic check_init(input string tag);
        #1 check({tag, "_tms_c1"}, 64'(tms_out), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_tms_c2"}, 64'(tms_out), 64'd0);
        check({tag, "_ready_c2"}, 64'(cmd_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_tap_rti"}, 64'(tap_state), 64'(RTI));
    endtask

    int seen;
    int tlr_snap;

    initial begin
        total     = 0;
        bad       = 0;
        trst_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;

        repeat (2) @(negedge clk);
        check("rst_tms", 64'(tms_out), 64'd1);
        check("rst_tdi", 64'(tdi_out), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_data", 64'(rsp_data), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);

        trst_n = 1'b1;
        check_init("init");

        send("ir4", 2'b01, 4, 32'h3, 32'hD, 1'b0, 11);
        check("ir4_tap_ir", 64'(tap_ir), 64'h3);

        tlr_snap = tlr_cnt;
        send("tapreset", 2'b00, 0, 32'h0, 32'h0, 1'b0, 7);
        check("tapreset_tlr", 64'(tlr_cnt - tlr_snap), 64'd3);
        check("tapreset_ir", 64'(tap_ir), 64'hF);
        check("tapreset_rti", 64'(tap_state), 64'(RTI));

        send("idle3", 2'b11, 3, 32'h0, 32'h0, 1'b0, 4);

        send("dr8", 2'b10, 8, 32'hA5, 32'h4A, 1'b0, 14);
        @(negedge clk);
        @(negedge clk);
        check("dr8_hold_valid", 64'(rsp_valid), 64'd0);
        check("dr8_hold_data", 64'(rsp_data), 64'h4A);

        send("rej_dr0", 2'b10, 0, 32'hFFFF, 32'h0, 1'b1, 1);
        send("rej_ir33", 2'b01, 33, 32'hFFFF, 32'h0, 1'b1, 1);
        send("idle0", 2'b11, 0, 32'h0, 32'h0, 1'b0, 1);

        // Back-to-back: valid stays high, second command waits for the first's rsp_valid.
        begin
            exp_t e;
            cmd_op = 2'b11; cmd_len = LW'(2); cmd_data = '0; cmd_valid = 1'b1;
            e.data = '0; e.err = 1'b0; e.cyc = 3;
            sb.push_back(e);
            @(posedge clk);
            #1;
            cmd_op = 2'b10; cmd_len = LW'(8); cmd_data = 32'h3C;
            e.data = 32'h78; e.err = 1'b0; e.cyc = 14;
            sb.push_back(e);
            watch("b2b_a", 2'b11, 2);
            check("b2b_ready", 64'(cmd_ready), 64'd1);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            watch("b2b_b", 2'b10, 8);
        end

        // Reset in cycle 5 of a 16-bit DR scan.
        cmd_op = 2'b10; cmd_len = LW'(16); cmd_data = 32'h1234; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 trst_n = 1'b0;
        #1;
        check("mid_tms", 64'(tms_out), 64'd1);
        check("mid_tdi", 64'(tdi_out), 64'd0);
        check("mid_ready", 64'(cmd_ready), 64'd0);
        check("mid_valid", 64'(rsp_valid), 64'd0);
        check("mid_data", 64'(rsp_data), 64'd0);
        check("mid_err", 64'(rsp_err), 64'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        trst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            #1 if (rsp_valid) seen++;
            if (i == 0) check_init("mid_init");
            else @(negedge clk);
        end
        check("mid_no_rsp", 64'(seen), 64'd0);

        send("post_dr8", 2'b10, 8, 32'h5A, 32'hB4, 1'b0, 14);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtag_shift_sequencer.md
# jtag_shift_sequencer

Command-driven JTAG master that drives TMS/TDI into the chip's TAP controller and collects TDO. It turns IR-scan, DR-scan, TAP-reset and idle commands into cycle-exact TMS/TDI sequences. It keeps the TAP parked in Run-Test/Idle between commands. It sits between an on-chip debug/BIST engine and the TAP, on the same clock.

## Interface
- DATA_WIDTH, 32, maximum scan length in bits; also the width of the data buses.
- LEN_WIDTH, 6, width of cmd_len; must hold DATA_WIDTH.
- clk  in  1  TAP clock. TMS/TDI launch on the rising edge; TDO is sampled on the rising edge.
- trst_n_pad_in  in  1  reset, asynchronous, active-low. Shared with the TAP.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  operation: 00 = TAP_RESET, 01 = IR_SCAN, 10 = DR_SCAN, 11 = IDLE.
- cmd_len  in  LEN_WIDTH  scan length in bits, or idle cycle count.
- cmd_data  in  DATA_WIDTH  TDI bits, shifted LSB first.
- tms_out  out  1  to TAP tms_pad_in.
- tdi_out  out  1  to TAP tdi_pad_in.
- tdo_in  in  1  from TAP tdo_pad_out.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_WIDTH  captured TDO bits, LSB = first bit out.
- rsp_err  out  1  the completed command was rejected.

## Operation
- States: INIT0, INIT1, IDLE, RST, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN, DONE.
- Reset values: tms_out=1, tdi_out=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, state=INIT0.
- After reset the sequencer drives TMS=0 for one cycle (INIT0→INIT1) to move the TAP from Test-Logic-Reset to Run-Test/Idle. The sequencer then enters IDLE.
- In IDLE: cmd_ready=1 and tms_out=0, so the TAP stays in Run-Test/Idle.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_op, cmd_len and cmd_data are captured only at that edge.
  - cmd_ready is low from the accept edge until DONE.
- TMS sequences, starting from Run-Test/Idle:
  - DR_SCAN, N bits: 1,0,0, then N-1 zeros, then 1,1,0.
  - IR_SCAN, N bits: 1,1,0,0, then N-1 zeros, then 1,1,0.
  - TAP_RESET: 1,1,1,1,1,0.
  - IDLE, L cycles: L zeros.
- Scan data path:
  - On the N edges at which the TAP is in Shift-xR, tdi_out = cmd_data[i], for i = 0..N-1.
  - tdo_in is sampled into rsp_data[i] on those same edges.
  - rsp_data bits at index N and above are 0.
  - tdi_out = 0 outside Shift.
- Rejects:
  - IR_SCAN or DR_SCAN with cmd_len=0 or cmd_len>DATA_WIDTH: no TMS activity (tms_out stays 0), rsp_err=1, rsp_data=0.
  - IDLE with L=0 is legal: no TMS activity, rsp_err=0.
- rsp_data and rsp_err hold their values until the next rsp_valid.
- Reset mid-operation (trst_n_pad_in low): all outputs return to reset values immediately. The command in flight is dropped with no rsp_valid. The INIT sequence restarts.

## Timing
- Cycle 1 is the cycle following the accept edge. The first TMS bit is on tms_out in cycle 1.
- DR_SCAN: TMS occupies cycles 1..N+5. rsp_valid and cmd_ready are high in cycle N+6.
- IR_SCAN: TMS occupies cycles 1..N+6. rsp_valid is high in cycle N+7.
- TAP_RESET: rsp_valid is high in cycle 7.
- IDLE: rsp_valid is high in cycle L+1.
- Reject: rsp_valid is high in cycle 1.
- cmd_ready rises in the same cycle as rsp_valid. A new command may be accepted at the end of that cycle, so back-to-back commands have no gap.
- After trst_n_pad_in deasserts, cmd_ready rises at the second rising clk edge.
- TDO sampling relies on the TAP updating tdo_pad_out on the falling clk edge. The value is stable at the sampling rising edge.

## Test plan
- Reset release:
  - Stimulus: release trst_n_pad_in.
  - Required: tms_out is 1 in the first cycle and 0 in the second. cmd_ready is high after the second edge. The TAP (the team's TAP controller, default parameters, wired to the sequencer) is in Run-Test/Idle.
- IR_SCAN:
  - Stimulus: IR_SCAN, len 4, data 4'b0011.
  - Required: rsp_valid in cycle 11 with rsp_data=4'b1101. The TAP instruction becomes 0011.
- DR_SCAN through BYPASS:
  - Stimulus: after reset, DR_SCAN, len 8, data 8'hA5.
  - Required: rsp_valid in cycle 14 with rsp_data=8'h4A, because of the one-bit bypass delay.
- TAP_RESET and IDLE:
  - Stimulus: TAP_RESET after loading IR 0011.
  - Required: the TAP passes through Test-Logic-Reset, the instruction returns to 1111, rsp_valid in cycle 7.
  - Stimulus: IDLE, len 3.
  - Required: tms_out=0 throughout, rsp_valid in cycle 4.
- Rejects:
  - Stimulus: DR_SCAN len 0, then IR_SCAN len 33.
  - Required: each gives rsp_valid in cycle 1 with rsp_err=1 and rsp_data=0. tms_out never leaves 0.
- Mid-scan reset and back-to-back:
  - Stimulus: assert trst_n_pad_in during cycle 5 of a DR_SCAN of len 16.
  - Required: immediate reset values, no rsp_valid, cmd_ready again at edge 2 after release.
  - Stimulus: hold cmd_valid high for two back-to-back commands.
  - Required: the second command is accepted in the rsp_valid cycle of the first.
